pipe_chain: RTL and testbench

Parametrised in-order pipeline register chain for the MIPS core. It replaces the fixed hand-wired E/M/W control and data registers with DEPTH uniform stages. Each stage carries a valid bit and its own stall and flush, so a stall produces a real bubble. A built-in scoreboard gives forwarding selects and load-use detection for two decode-stage source registers.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_stage.sv | 41 ++++
 rtl/pipe_chain.sv | 114 +++++++++++
 tb/tb_pipe_chain.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings and the per-stage control record for the pipeline register chain.
// Forwarding/load-use logic in pipe_chain is built only when PIPE_CHAIN_FWD_EN is defined.
package pipe_pkg;

    localparam int FWD_RF   = 0;
    localparam int REG_ZERO = 0;

    // Control part of a stage record; wreg and data sit beside it with parametrised widths.
    typedef struct packed {
        logic valid;
        logic wen;
        logic isload;
    } stageCtrl_t;

    localparam stageCtrl_t CTRL_EMPTY = '{valid: 1'b0, wen: 1'b0, isload: 1'b0};

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage register: priority reset/flush, hold, bubble, then load.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             hold,
    input  logic             bubble,
    input  stageCtrl_t       ctrlIn,
    input  logic [REGW-1:0]  wregIn,
    input  logic [WIDTH-1:0] dataIn,
    output stageCtrl_t       ctrlQ,
    output logic [REGW-1:0]  wregQ,
    output logic [WIDTH-1:0] dataQ
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ctrlQ <= CTRL_EMPTY;
            wregQ <= '0;
            dataQ <= '0;
        end else if (hold) begin
            ctrlQ <= ctrlQ;
            wregQ <= wregQ;
            dataQ <= dataQ;
        end else if (bubble) begin
            ctrlQ <= CTRL_EMPTY;
            wregQ <= '0;
            dataQ <= '0;
        end else begin
            ctrlQ <= ctrlIn;
            wregQ <= wregIn;
            dataQ <= dataIn;
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// Parametrised in-order pipeline register chain with per-stage stall/flush and an
// optional forwarding scoreboard (enabled by defining PIPE_CHAIN_FWD_EN).
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int WIDTH = 32,
    parameter int REGW  = 5,
    parameter int FW    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [REGW-1:0]         in_wreg,
    input  logic                    in_wen,
    input  logic                    in_isload,
    output logic                    in_ready,
    input  logic [DEPTH-1:0]        stall,
    input  logic [DEPTH-1:0]        flush,
    output logic [DEPTH-1:0]        st_valid,
    output logic [DEPTH*WIDTH-1:0]  st_data,
    output logic [DEPTH*REGW-1:0]   st_wreg,
    output logic [DEPTH-1:0]        st_wen,
    output logic [DEPTH-1:0]        st_isload,
    input  logic [REGW-1:0]         src_a,
    input  logic [REGW-1:0]         src_b,
    output logic [FW-1:0]           fwd_a,
    output logic [FW-1:0]           fwd_b,
    output logic                    ld_use
);

    logic [DEPTH-1:0] holdVec;
    stageCtrl_t       ctrl [DEPTH];
    logic [REGW-1:0]  wreg [DEPTH];
    logic [WIDTH-1:0] data [DEPTH];

    // A stall anywhere downstream freezes every younger stage.
    always_comb begin
        holdVec = stall;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            holdVec[k] = stall[k] | holdVec[k+1];
        end
    end

    assign in_ready = ~holdVec[0];

    for (genvar k = 0; k < DEPTH; k++) begin : gStage
        stageCtrl_t       ctrlIn;
        logic [REGW-1:0]  wregIn;
        logic [WIDTH-1:0] dataIn;
        logic             bubble;

        if (k == 0) begin : gHead
            assign ctrlIn = '{valid: in_valid, wen: in_valid & in_wen, isload: in_valid & in_isload};
            assign wregIn = in_wreg;
            assign dataIn = in_data;
            assign bubble = 1'b0;
        end else begin : gBody
            assign ctrlIn = ctrl[k-1];
            assign wregIn = wreg[k-1];
            assign dataIn = data[k-1];
            assign bubble = holdVec[k-1];
        end

        pipe_stage #(
            .WIDTH (WIDTH),
            .REGW  (REGW)
        ) uStage (
            .clk    (clk),
            .rst    (rst),
            .flush  (flush[k]),
            .hold   (holdVec[k]),
            .bubble (bubble),
            .ctrlIn (ctrlIn),
            .wregIn (wregIn),
            .dataIn (dataIn),
            .ctrlQ  (ctrl[k]),
            .wregQ  (wreg[k]),
            .dataQ  (data[k])
        );

        assign st_valid[k]               = ctrl[k].valid;
        assign st_wen[k]                 = ctrl[k].wen;
        assign st_isload[k]              = ctrl[k].isload;
        assign st_wreg[k*REGW +: REGW]   = wreg[k];
        assign st_data[k*WIDTH +: WIDTH] = data[k];
    end

`ifdef PIPE_CHAIN_FWD_EN
    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        fwd_a = FW'(FWD_RF);
        fwd_b = FW'(FWD_RF);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ctrl[k].valid && ctrl[k].wen && wreg[k] == src_a && src_a != REGW'(REG_ZERO))
                fwd_a = FW'(k + 1);
            if (ctrl[k].valid && ctrl[k].wen && wreg[k] == src_b && src_b != REGW'(REG_ZERO))
                fwd_b = FW'(k + 1);
        end
    end

    assign ld_use = ctrl[0].valid & ctrl[0].isload & ctrl[0].wen
                  & (wreg[0] != REGW'(REG_ZERO))
                  & ((wreg[0] == src_a) | (wreg[0] == src_b));
`else
    logic unusedSrc;
    assign unusedSrc = ^{src_a, src_b};
    assign fwd_a     = FW'(FWD_RF);
    assign fwd_b     = FW'(FWD_RF);
    assign ld_use    = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain (DEPTH=3): flow, stall bubbles, flush priority,
// forwarding selects, load-use and mid-stream reset.
module tb_pipe_chain;

    localparam int DEPTH = 3;
    localparam int WIDTH = 32;
    localparam int REGW  = 5;
    localparam int FW    = $clog2(DEPTH + 1);
`ifdef PIPE_CHAIN_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic [REGW-1:0]        in_wreg;
    logic                   in_wen;
    logic                   in_isload;
    logic                   in_ready;
    logic [DEPTH-1:0]       stall;
    logic [DEPTH-1:0]       flush;
    logic [DEPTH-1:0]       st_valid;
    logic [DEPTH*WIDTH-1:0] st_data;
    logic [DEPTH*REGW-1:0]  st_wreg;
    logic [DEPTH-1:0]       st_wen;
    logic [DEPTH-1:0]       st_isload;
    logic [REGW-1:0]        src_a;
    logic [REGW-1:0]        src_b;
    logic [FW-1:0]          fwd_a;
    logic [FW-1:0]          fwd_b;
    logic                   ld_use;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_chain #(.DEPTH(DEPTH), .WIDTH(WIDTH), .REGW(REGW), .FW(FW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_wreg   (in_wreg),
        .in_wen    (in_wen),
        .in_isload (in_isload),
        .in_ready  (in_ready),
        .stall     (stall),
        .flush     (flush),
        .st_valid  (st_valid),
        .st_data   (st_data),
        .st_wreg   (st_wreg),
        .st_wen    (st_wen),
        .st_isload (st_isload),
        .src_a     (src_a),
        .src_b     (src_b),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .ld_use    (ld_use)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic [REGW-1:0] r,
                        input logic we, input logic ld);
        in_valid  = 1'b1;
        in_data   = d;
        in_wreg   = r;
        in_wen    = we;
        in_isload = ld;
    endtask

    function automatic logic [WIDTH-1:0] dat(input int k);
        return st_data[k*WIDTH +: WIDTH];
    endfunction

    function automatic logic [REGW-1:0] wr(input int k);
        return st_wreg[k*REGW +: REGW];
    endfunction

    initial begin
        rst = 1'b1; stall = '0; flush = '0; src_a = 5'd8; src_b = 5'd0;
        push(32'hAAAA_0001, 5'd8, 1'b1, 1'b0);
        #1;
        step();
        check("rst_valid", st_valid, 3'b000);
        check("rst_data", st_data, '0);
        check("rst_fwd_a", fwd_a, 2'd0);
        check("rst_ld_use", ld_use, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // Flow: A travels one stage per edge and leaves after stage 2
        rst = 1'b0;
        push(32'hA, 5'd8, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        check("flow_c1_valid", st_valid, 3'b001);
        check("flow_c1_data", dat(0), 32'hA);
        check("flow_c1_wreg", wr(0), 5'd8);
        check("flow_c1_fwd_a", fwd_a, FWD_ON ? 2'd1 : 2'd0);
        step();
        check("flow_c2_valid", st_valid, 3'b010);
        check("flow_c2_fwd_a", fwd_a, FWD_ON ? 2'd2 : 2'd0);
        step();
        check("flow_c3_valid", st_valid, 3'b100);
        check("flow_c3_data", dat(2), 32'hA);
        check("flow_c3_fwd_a", fwd_a, FWD_ON ? 2'd3 : 2'd0);
        step();
        check("flow_c4_valid", st_valid, 3'b000);
        check("flow_c4_fwd_a", fwd_a, 2'd0);

        // Stall on stage 1 holds stages 0/1 and bubbles stage 2
        push(32'hB, 5'd3, 1'b1, 1'b0);
        step();
        push(32'hC, 5'd4, 1'b1, 1'b0);
        step();
        check("stall_pre_valid", st_valid, 3'b011);
        stall = 3'b010;
        push(32'hD, 5'd5, 1'b1, 1'b0);
        #1;
        check("stall_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_valid", st_valid, 3'b011);
            check("stall_st0", dat(0), 32'hC);
            check("stall_st1", dat(1), 32'hB);
            check("stall_in_ready_hold", in_ready, 1'b0);
        end
        stall = '0;
        in_valid = 1'b0;
        #1;
        check("release_in_ready", in_ready, 1'b1);
        step();
        check("release_valid", st_valid, 3'b110);
        check("release_st1", dat(1), 32'hC);
        check("release_st2", dat(2), 32'hB);
        step();
        check("release2_valid", st_valid, 3'b100);
        check("release2_st2", dat(2), 32'hC);
        step();
        check("release3_valid", st_valid, 3'b000);

        // Flush beats stall on stage 0; held stages 1/2 keep their contents
        push(32'hE, 5'd6, 1'b1, 1'b0);
        step();
        push(32'hF, 5'd7, 1'b1, 1'b0);
        step();
        push(32'h6, 5'd10, 1'b1, 1'b0);
        step();
        check("fill_valid", st_valid, 3'b111);
        stall = 3'b111;
        flush = 3'b001;
        push(32'h7, 5'd11, 1'b1, 1'b0);
        step();
        check("flush_valid", st_valid, 3'b110);
        check("flush_st0_data", dat(0), 32'h0);
        check("flush_st1", dat(1), 32'hF);
        check("flush_st2", dat(2), 32'hE);
        stall = '0;
        flush = '0;
        in_valid = 1'b0;
        step();
        check("flush_drain_valid", st_valid, 3'b100);
        check("flush_drain_st2", dat(2), 32'hF);
        step();
        check("flush_drain2_valid", st_valid, 3'b000);

        // Forwarding: st2 wreg 0, st1 and st0 both wreg 8
        push(32'h10, 5'd0, 1'b1, 1'b0);
        step();
        push(32'h11, 5'd8, 1'b1, 1'b0);
        step();
        push(32'h12, 5'd8, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        stall = 3'b111;
        src_a = 5'd8;
        src_b = 5'd0;
        #1;
        check("fwd_youngest_a", fwd_a, FWD_ON ? 2'd1 : 2'd0);
        check("fwd_zero_b", fwd_b, 2'd0);
        check("fwd_no_load", ld_use, 1'b0);
        src_a = 5'd3;
        src_b = 5'd8;
        #1;
        check("fwd_miss_a", fwd_a, 2'd0);
        check("fwd_b8", fwd_b, FWD_ON ? 2'd1 : 2'd0);
        src_a = 5'd8;
        flush = 3'b001;
        step();
        flush = '0;
        #1;
        check("fwd_after_flush_a", fwd_a, FWD_ON ? 2'd2 : 2'd0);

        // Load-use on stage 0
        stall = '0;
        flush = 3'b111;
        step();
        flush = '0;
        check("lu_cleared", st_valid, 3'b000);
        push(32'h20, 5'd9, 1'b1, 1'b1);
        step();
        in_valid = 1'b0;
        stall = 3'b111;
        src_a = 5'd1;
        src_b = 5'd9;
        #1;
        check("lu_isload", st_isload, 3'b001);
        check("lu_hit_b", ld_use, FWD_ON ? 1'b1 : 1'b0);
        check("lu_fwd_b", fwd_b, FWD_ON ? 2'd1 : 2'd0);
        src_b = 5'd0;
        #1;
        check("lu_src_zero", ld_use, 1'b0);
        src_a = 5'd9;
        #1;
        check("lu_hit_a", ld_use, FWD_ON ? 1'b1 : 1'b0);
        stall = '0;
        flush = 3'b111;
        step();
        flush = '0;
        push(32'h21, 5'd9, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        stall = 3'b111;
        src_a = 5'd1;
        src_b = 5'd9;
        #1;
        check("lu_nowen_wen", st_wen, 3'b000);
        check("lu_nowen", ld_use, 1'b0);
        check("lu_nowen_fwd", fwd_b, 2'd0);

        // Reset mid-stream overrides stall
        stall = '0;
        push(32'h30, 5'd12, 1'b1, 1'b0);
        step();
        push(32'h31, 5'd13, 1'b1, 1'b0);
        step();
        check("pre_rst_valid", st_valid, 3'b111);
        rst = 1'b1;
        stall = 3'b111;
        flush = 3'b010;
        step();
        check("mid_rst_valid", st_valid, 3'b000);
        check("mid_rst_data", st_data, '0);
        check("mid_rst_wreg", st_wreg, '0);
        rst = 1'b0;
        stall = '0;
        flush = '0;
        in_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
